// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin memory bus arbiter with wait timeout
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        err,
  output logic        grant,
  output logic        arb_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        re_q, re_d;
  logic        mwe_q, mwe_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        win;
  logic        finish;

  // m1 wins only if it asks alone, or on a tie when m0 was served last.
  assign win = m1_req & (~m0_req | ~last_q);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    grant_d  = grant_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
    re_d     = 1'b0;
    mwe_d    = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d = win;
          we_d    = win ? m1_we    : m0_we;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          re_d    = ~(win ? m1_we : m0_we);
          mwe_d   = win ? m1_we : m0_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!mem_busy) begin
          if (!we_q) begin
            if (grant_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
          finish = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          if (grant_q) rdata1_d = 32'h0;
          else         rdata0_d = 32'h0;
          err_d  = 1'b1;
          finish = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (finish) begin
          ack0_d  = ~grant_q;
          ack1_d  = grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      re_q     <= 1'b0;
      mwe_q    <= 1'b0;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      re_q     <= re_d;
      mwe_q    <= mwe_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign err       = err_q;
  assign grant     = grant_q;
  assign arb_busy  = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mwe_q;
  assign mem_re    = re_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - vector-table bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we, mem_busy;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic        m0_ack, m1_ack, err, grant, arb_busy, mem_we, mem_re;
  logic [31:0] t4_m0_rdata, t4_m1_rdata, t4_mem_addr, t4_mem_wdata;
  logic        t4_m0_ack, t4_m1_ack, t4_err, t4_grant, t4_arb_busy, t4_mem_we, t4_mem_re;

  mem_bus_arbiter u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .err(err), .grant(grant), .arb_busy(arb_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  mem_bus_arbiter #(.TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(t4_m0_rdata), .m0_ack(t4_m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(t4_m1_rdata), .m1_ack(t4_m1_ack),
    .err(t4_err), .grant(t4_grant), .arb_busy(t4_arb_busy),
    .mem_addr(t4_mem_addr), .mem_wdata(t4_mem_wdata), .mem_we(t4_mem_we), .mem_re(t4_mem_re),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0;
    logic        we0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        we1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [31:0] mrd;
    int          busy;
    logic        g;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_rd0 = 32'h0;
  logic [31:0] exp_rd1 = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ((mem_re && mem_we) || (t4_mem_re && t4_mem_we)) begin
        n_bad++;
        $display("FAIL strobe_overlap: re/we both high at %0t", $time);
      end
      if ((m0_ack && m1_ack) || (t4_m0_ack && t4_m1_ack)) begin
        n_bad++;
        $display("FAIL ack_overlap: both acks high at %0t", $time);
      end
    end
  end

  task automatic run_vec(input vec_t v, input bit from_idle, input int idx);
    int          gap;
    int          c;
    bit          got;
    logic        ewe;
    logic [31:0] ea, ed;
    m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
    mem_rdata = v.mrd;
    mem_busy  = 1'b0;
    ewe = v.g ? v.we1 : v.we0;
    ea  = v.g ? v.a1  : v.a0;
    ed  = v.g ? v.d1  : v.d0;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!(mem_re || mem_we) && gap < 10);
    chk($sformatf("v%0d issue_gap", idx), 32'(gap), from_idle ? 32'd1 : 32'd2);
    chk($sformatf("v%0d grant", idx), {31'h0, grant}, {31'h0, v.g});
    chk($sformatf("v%0d strobes", idx), {30'h0, mem_re, mem_we}, {30'h0, ~ewe, ewe});
    chk($sformatf("v%0d mem_addr", idx), mem_addr, ea);
    chk($sformatf("v%0d mem_wdata", idx), mem_wdata, ed);
    chk($sformatf("v%0d arb_busy", idx), {31'h0, arb_busy}, 32'd1);
    mem_busy = (v.busy > 0);
    c   = 0;
    got = 1'b0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      mem_busy = (c <= v.busy);
      if (mem_re || mem_we || mem_addr !== ea || mem_wdata !== ed || grant !== v.g) begin
        n_bad++;
        $display("FAIL v%0d hold: cycle %0d re=%b we=%b addr=%h wdata=%h grant=%b", idx, c,
                 mem_re, mem_we, mem_addr, mem_wdata, grant);
      end
      if ((v.g ? m0_ack : m1_ack) === 1'b1) begin
        n_bad++;
        $display("FAIL v%0d other_ack: non-granted master acked", idx);
      end
      got = v.g ? m1_ack : m0_ack;
    end
    if (!ewe) begin
      if (v.g) exp_rd1 = v.mrd;
      else     exp_rd0 = v.mrd;
    end
    chk($sformatf("v%0d ack_latency", idx), 32'(c + 1), 32'(3 + v.busy));
    chk($sformatf("v%0d err", idx), {31'h0, err}, 32'd0);
    chk($sformatf("v%0d m0_rdata", idx), m0_rdata, exp_rd0);
    chk($sformatf("v%0d m1_rdata", idx), m1_rdata, exp_rd1);
  endtask

  vec_t vecs[9];

  initial begin
    int c;
    vecs[0] = '{1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 32'h11111111, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 32'h22222222, 1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 32'h33333333, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 32'h44444444, 3, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 32'h0100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0200, 32'h12345678, 32'hDEADBEEF, 5, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h0300, 32'h0BADF00D, 1'b1, 1'b0, 32'h0400, 32'h0, 32'h5A5A5A5A, 1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h0300, 32'h0BADF00D, 1'b1, 1'b0, 32'h0400, 32'h0, 32'h55AA55AA, 2, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 32'h0900, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h13572468, 0, 1'b0};

    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    mem_rdata = 0; mem_busy = 0;
    repeat (2) @(negedge clk);
    chk("rst grant_busy_err", {29'h0, grant, arb_busy, err}, 32'd0);
    chk("rst strobes_acks", {28'h0, mem_re, mem_we, m0_ack, m1_ack}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst m0_rdata", m0_rdata, 32'h0);
    chk("rst m1_rdata", m1_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], (i == 0), i);

    // Timeout on the TIMEOUT=4 instance, then a normal read straight after.
    @(negedge clk);
    m0_req = 0; m1_req = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h0500; m0_wdata = 32'h5A5A5A5A;
    mem_rdata = 32'h99999999; mem_busy = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!t4_m0_ack && c < 20);
    chk("to ack_latency", 32'(c), 32'd6);
    chk("to ack_err", {30'h0, t4_m0_ack, t4_err}, 32'd3);
    chk("to m0_rdata", t4_m0_rdata, 32'h0);
    chk("to hold", {t4_mem_addr[29:0], t4_grant, t4_arb_busy}, {30'h0500, 1'b0, 1'b1});
    chk("to mem_wdata", t4_mem_wdata, 32'h5A5A5A5A);
    m0_addr = 32'h0600; mem_rdata = 32'h77777777; mem_busy = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!t4_m0_ack && c < 20);
    chk("to2 ack_latency", 32'(c), 32'd4);
    chk("to2 err", {31'h0, t4_err}, 32'd0);
    chk("to2 m0_rdata", t4_m0_rdata, 32'h77777777);
    chk("to2 m1_rdata", t4_m1_rdata, 32'h0);

    // Reset in the middle of WAIT while m1 owns the bus.
    m0_req = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h0800; m1_wdata = 32'h0;
    mem_busy = 1'b1;
    @(negedge clk);
    chk("rw pre_grant", {31'h0, grant}, 32'd1);
    @(negedge clk);
    #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h0700; m0_wdata = 32'h0;
    rst = 1'b1;
    #1;
    chk("rw async_state", {28'h0, grant, arb_busy, mem_re, mem_we}, 32'd0);
    chk("rw async_acks", {29'h0, m0_ack, m1_ack, err}, 32'd0);
    chk("rw async_addr", mem_addr, 32'h0);
    @(negedge clk);
    chk("rw held_outputs", {27'h0, mem_re, mem_we, m0_ack, m1_ack, arb_busy}, 32'd0);
    rst = 1'b0;
    mem_busy = 1'b0;
    @(negedge clk);
    chk("rw first_grant", {30'h0, grant, mem_re}, 32'd1);
    chk("rw first_addr", mem_addr, 32'h0700);
    m0_req = 0; m1_req = 0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
